// File: rtl/microarchtrace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microarchtrace_pkg
// Description : Shared record kinds, field widths and state encodings for the
//               microarchitecture trace encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package microarchtrace_pkg;

    typedef enum logic [2:0] {
        KIND_SINGLE   = 3'd0,
        KIND_START    = 3'd1,
        KIND_END      = 3'd2,
        KIND_ABORT    = 3'd3,
        KIND_OVERFLOW = 3'd4,
        KIND_WRAP     = 3'd5
    } trace_kind_e;

    localparam int c_KIND_W    = 3;
    localparam int c_PAYLOAD_W = 32;
    localparam int c_DROP_W    = 16;

    // Record layout for the default configuration (2 stages, 16-bit timestamp)
    localparam int c_DEF_SID_W = 1;
    localparam int c_DEF_TS_W  = 16;

    typedef struct packed {
        trace_kind_e                kind;
        logic [c_DEF_SID_W-1:0]     stage;
        logic [c_DEF_TS_W-1:0]      ts;
        logic [c_PAYLOAD_W-1:0]     payload;
    } trace_rec_t;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    function automatic int sid_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Synchronous first-word-fall-through FIFO with a registered
//               head; the head holds its last value once the FIFO drains.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int c_AW  = $clog2(DEPTH),
    localparam int c_LW  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [c_LW-1:0]  level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic [WIDTH-1:0] r_dout;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = pop && (r_level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push_ok = push && ((r_level != c_LW'(DEPTH)) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_pop_ok && (r_level > c_LW'(1))) begin
                r_dout <= r_mem[r_rd_ptr + 1'b1];
            end else if (w_push_ok && ((r_level == '0) || w_pop_ok)) begin
                r_dout <= wdata;
            end
        end
    end

    assign full  = (r_level == c_LW'(DEPTH));
    assign empty = (r_level == '0);
    assign level = r_level;
    assign rdata = r_dout;

endmodule
`default_nettype wire

// File: rtl/microarch_trace_encoder.sv
`default_nettype none
// ============================================================================
// Module      : microarch_trace_encoder
// Description : Per-stage execution classifier, timestamping, drop accounting
//               and round-robin arbitration into a record FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module microarch_trace_encoder
    import microarchtrace_pkg::*;
#(
    parameter  int N_STAGES = 2,
    parameter  int TS_W     = 16,
    parameter  int DEPTH    = 16,
    localparam int c_SID_W  = sid_width(N_STAGES),
    localparam int c_REC_W  = c_KIND_W + c_SID_W + TS_W + c_PAYLOAD_W,
    localparam int c_LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trace_en,
    input  logic [N_STAGES-1:0]     stage_act,
    input  logic [N_STAGES-1:0]     stage_done,
    input  logic [32*N_STAGES-1:0]  stage_pc,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [c_REC_W-1:0]      rec_data,
    output logic [c_DROP_W-1:0]     drop_count,
    output logic [c_LVL_W-1:0]      fifo_level
);

    logic [TS_W-1:0]      r_ts;
    logic                 r_wrap_pend;
    logic [c_DROP_W-1:0]  r_drop_count;
    logic [c_DROP_W-1:0]  r_drop_delta;
    logic [c_SID_W-1:0]   r_rr_ptr;
    logic [c_SID_W-1:0]   w_rr_sel;
    logic                 w_rr_found;
    int                   w_best_dist;
    logic [N_STAGES-1:0]  w_hold_v;
    logic [N_STAGES-1:0]  w_evt_drop;
    logic [N_STAGES-1:0]  w_drain;
    logic [c_REC_W-1:0]   w_hold_rec [N_STAGES];
    logic [c_REC_W-1:0]   w_stage_rec;
    logic [c_REC_W-1:0]   w_wr_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic                 w_can_wr;
    logic                 w_wr_ovf;
    logic                 w_wr_wrap;
    logic                 w_wr_stage;
    logic                 w_push;
    logic [c_DROP_W-1:0]  w_drop_n;
    logic [c_DROP_W:0]    w_drop_sum;
    logic [c_DROP_W:0]    w_delta_sum;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        logic [0:0]         r_state;
        logic [0:0]         w_state_nxt;
        logic               w_evt;
        trace_kind_e        w_kind;
        logic               r_hold_v;
        logic [c_REC_W-1:0] r_hold_rec;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= c_ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            if (!trace_en) begin
                w_state_nxt = c_ST_IDLE;
            end else begin
                case (r_state)
                    c_ST_IDLE: if (stage_act[g] && !stage_done[g]) w_state_nxt = c_ST_BUSY;
                    c_ST_BUSY: if (!stage_act[g] || stage_done[g]) w_state_nxt = c_ST_IDLE;
                    default:   w_state_nxt = c_ST_IDLE;
                endcase
            end
        end

        always_comb begin
            w_evt  = 1'b0;
            w_kind = KIND_SINGLE;
            if (trace_en) begin
                case (r_state)
                    c_ST_IDLE: begin
                        w_evt  = stage_act[g];
                        w_kind = stage_done[g] ? KIND_SINGLE : KIND_START;
                    end
                    c_ST_BUSY: begin
                        w_evt  = !stage_act[g] || stage_done[g];
                        w_kind = !stage_act[g] ? KIND_ABORT : KIND_END;
                    end
                    default: w_evt = 1'b0;
                endcase
            end
        end

        // A draining register can take a new event in the same cycle
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hold_v   <= 1'b0;
                r_hold_rec <= '0;
            end else if (w_evt && (!r_hold_v || w_drain[g])) begin
                r_hold_v   <= 1'b1;
                r_hold_rec <= {w_kind, c_SID_W'(g), r_ts, stage_pc[32*g +: 32]};
            end else if (w_drain[g]) begin
                r_hold_v   <= 1'b0;
            end
        end

        assign w_hold_v[g]   = r_hold_v;
        assign w_hold_rec[g] = r_hold_rec;
        assign w_evt_drop[g] = w_evt && r_hold_v && !w_drain[g];
        assign w_drain[g]    = w_wr_stage && (w_rr_sel == c_SID_W'(g));
    end

    // Closest pending stage at or after the round-robin pointer wins
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_sel    = '0;
        w_best_dist = N_STAGES;
        w_stage_rec = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (w_hold_v[i] && (((i + N_STAGES - int'(r_rr_ptr)) % N_STAGES) < w_best_dist)) begin
                w_best_dist = (i + N_STAGES - int'(r_rr_ptr)) % N_STAGES;
                w_rr_sel    = c_SID_W'(i);
                w_rr_found  = 1'b1;
                w_stage_rec = w_hold_rec[i];
            end
        end
    end

    assign w_pop      = rec_valid && rec_ready;
    assign w_can_wr   = !w_fifo_full || w_pop;
    assign w_wr_ovf   = w_can_wr && (r_drop_delta != '0);
    assign w_wr_wrap  = w_can_wr && (r_drop_delta == '0) && r_wrap_pend;
    assign w_wr_stage = w_can_wr && (r_drop_delta == '0) && !r_wrap_pend && w_rr_found;
    assign w_push     = w_wr_ovf || w_wr_wrap || w_wr_stage;

    always_comb begin
        w_wr_data = w_stage_rec;
        if (w_wr_ovf) begin
            w_wr_data = {KIND_OVERFLOW, c_SID_W'(0), r_ts, 16'h0000, r_drop_delta};
        end else if (w_wr_wrap) begin
            w_wr_data = {KIND_WRAP, c_SID_W'(0), TS_W'(0), 32'h0000_0000};
        end
    end

    assign w_drop_n    = c_DROP_W'($countones(w_evt_drop));
    assign w_drop_sum  = {1'b0, r_drop_count} + {1'b0, w_drop_n};
    assign w_delta_sum = (w_wr_ovf ? '0 : {1'b0, r_drop_delta}) + {1'b0, w_drop_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts         <= '0;
            r_wrap_pend  <= 1'b0;
            r_drop_count <= '0;
            r_drop_delta <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_ts         <= r_ts + 1'b1;
            r_wrap_pend  <= (r_wrap_pend && !w_wr_wrap) || ((&r_ts) && trace_en);
            r_drop_count <= w_drop_sum[c_DROP_W]  ? '1 : w_drop_sum[c_DROP_W-1:0];
            r_drop_delta <= w_delta_sum[c_DROP_W] ? '1 : w_delta_sum[c_DROP_W-1:0];
            if (w_wr_stage) begin
                r_rr_ptr <= (w_rr_sel == c_SID_W'(N_STAGES - 1)) ? '0 : w_rr_sel + 1'b1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_wr_data),
        .full  (w_fifo_full),
        .pop   (w_pop),
        .rdata (rec_data),
        .empty (w_fifo_empty),
        .level (fifo_level)
    );

    assign rec_valid  = !w_fifo_empty;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_microarch_trace_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_microarch_trace_encoder
// Description : Scoreboard bench: a transaction model predicts every record,
//               occupancy and drop count; a monitor compares on handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microarch_trace_encoder;

    localparam int N     = 2;
    localparam int TSW   = 4;
    localparam int DEPTH = 16;
    localparam int REC_W = 3 + 1 + TSW + 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trace_en = 1'b0;
    logic [N-1:0]     stage_act = '0;
    logic [N-1:0]     stage_done = '0;
    logic [32*N-1:0]  stage_pc = '0;
    logic             rec_ready = 1'b0;
    logic             rec_valid;
    logic [REC_W-1:0] rec_data;
    logic [15:0]      drop_count;
    logic [4:0]       fifo_level;

    microarch_trace_encoder #(
        .N_STAGES (N),
        .TS_W     (TSW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_en   (trace_en),
        .stage_act  (stage_act),
        .stage_done (stage_done),
        .stage_pc   (stage_pc),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_wrap_seen = 0;

    // Reference model state
    int               m_ts = 0, m_level = 0, m_drop = 0, m_delta = 0, m_rr = 0;
    bit               m_wrap = 0;
    bit               m_busy   [N];
    bit               m_hold_v [N];
    logic [REC_W-1:0] m_hold   [N];
    logic [REC_W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: one arbitration slot per cycle, then event capture
    always @(posedge clk or posedge rst) begin : model
        int               gnt, drops, base;
        bit               pop, evt, have_wr;
        logic [2:0]       kind;
        logic [REC_W-1:0] wr;
        if (rst) begin
            m_ts = 0; m_level = 0; m_drop = 0; m_delta = 0; m_rr = 0; m_wrap = 0;
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_hold_v[i] = 0; m_hold[i] = '0;
            end
            exp_q.delete();
        end else begin
            pop = (m_level > 0) && rec_ready;
            have_wr = 0; gnt = -1; base = m_delta; wr = '0;
            if (m_level < DEPTH || pop) begin
                if (m_delta != 0) begin
                    wr = {3'd4, 1'b0, 4'(m_ts), 32'(m_delta)}; have_wr = 1; base = 0;
                end else if (m_wrap) begin
                    wr = {3'd5, 37'd0}; have_wr = 1; m_wrap = 0;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (gnt < 0 && m_hold_v[(m_rr + k) % N]) gnt = (m_rr + k) % N;
                    if (gnt >= 0) begin
                        wr = m_hold[gnt]; have_wr = 1; m_hold_v[gnt] = 0; m_rr = (gnt + 1) % N;
                    end
                end
            end
            if (have_wr) begin
                exp_q.push_back(wr);
                m_level++;
            end
            drops = 0;
            for (int i = 0; i < N; i++) begin
                evt = 0; kind = 3'd0;
                if (!trace_en) m_busy[i] = 0;
                else if (!m_busy[i]) begin
                    if (stage_act[i]) begin
                        evt = 1; kind = stage_done[i] ? 3'd0 : 3'd1; m_busy[i] = !stage_done[i];
                    end
                end else if (!stage_act[i]) begin
                    evt = 1; kind = 3'd3; m_busy[i] = 0;
                end else if (stage_done[i]) begin
                    evt = 1; kind = 3'd2; m_busy[i] = 0;
                end
                if (evt) begin
                    if (!m_hold_v[i]) begin
                        m_hold_v[i] = 1;
                        m_hold[i] = {kind, 1'(i), 4'(m_ts), stage_pc[32*i +: 32]};
                    end else drops++;
                end
            end
            m_drop  = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
            m_delta = (base + drops > 65535) ? 65535 : base + drops;
            if (trace_en && m_ts == 15) m_wrap = 1;
            m_ts = (m_ts + 1) % 16;
            if (pop) m_level--;
        end
    end

    always @(negedge clk) begin : monitor
        logic [REC_W-1:0] e;
        if (!rst) begin
            chk("rec_valid", 64'(rec_valid), 64'(m_level != 0));
            chk("fifo_level", 64'(fifo_level), 64'(m_level));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_record: got %0h expected none at t=%0t", rec_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec_data", 64'(rec_data), 64'(e));
                    if (rec_data[REC_W-1 -: 3] == 3'd5) n_wrap_seen++;
                end
            end
        end
    end

    task automatic step(input logic en, input logic [1:0] act, input logic [1:0] done, input logic rdy);
        @(posedge clk);
        #1;
        trace_en   = en;
        stage_act  = act;
        stage_done = done;
        rec_ready  = rdy;
        stage_pc   = {$urandom, $urandom};
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int wrap0;
        int guard;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(rec_valid), 64'd0);
        chk("reset_data", 64'(rec_data), 64'd0);
        chk("reset_drops", 64'(drop_count), 64'd0);
        chk("reset_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;

        // One full timestamp period with quiet stages yields exactly one WRAP
        wrap0 = n_wrap_seen;
        repeat (20) step(1'b1, 2'b00, 2'b00, 1'b1);
        chk("wrap_once", 64'(n_wrap_seen - wrap0), 64'd1);

        step(1'b1, 2'b01, 2'b01, 1'b1);
        repeat (4) step(1'b1, 2'b00, 2'b00, 1'b1);
        repeat (3) step(1'b1, 2'b10, 2'b00, 1'b1);
        step(1'b1, 2'b10, 2'b10, 1'b1);
        repeat (4) step(1'b1, 2'b00, 2'b00, 1'b1);
        repeat (2) step(1'b1, 2'b01, 2'b00, 1'b1);
        repeat (5) step(1'b1, 2'b00, 2'b00, 1'b1);

        repeat (30) step(1'b1, 2'b01, 2'b01, 1'b0);
        chk("bp_level_full", 64'(fifo_level), 64'd16);
        chk("bp_drops_seen", 64'(drop_count != 16'd0), 64'd1);
        repeat (30) step(1'b1, 2'b00, 2'b00, 1'b1);

        repeat (3) step(1'b1, 2'b11, 2'b11, 1'b1);
        repeat (10) step(1'b1, 2'b00, 2'b00, 1'b1);

        repeat (1500) step($urandom_range(0, 15) != 0, 2'($urandom), 2'($urandom),
                           $urandom_range(0, 9) < 7);

        // Reset while stage 1 is mid-instruction
        repeat (3) step(1'b1, 2'b10, 2'b00, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        stage_act = '0;
        stage_done = '0;
        #1;
        chk("midrst_valid", 64'(rec_valid), 64'd0);
        chk("midrst_data", 64'(rec_data), 64'd0);
        chk("midrst_drops", 64'(drop_count), 64'd0);
        chk("midrst_level", 64'(fifo_level), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 2'b10, 2'b10, 1'b1);
        repeat (6) step(1'b1, 2'b00, 2'b00, 1'b1);

        guard = 0;
        while (m_level != 0 && guard < 200) begin
            step(1'b0, 2'b00, 2'b00, 1'b1);
            guard++;
        end
        repeat (3) step(1'b0, 2'b00, 2'b00, 1'b1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
